// File: rtl/serial_pat_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
//   tx_state_e : transmitter FSM state (idle, shifting bits, inter-pattern gap, done pulse)
//   DefPatW    : default pattern length in bits
//   DefCntW    : default width of the repeat and gap counts
package serial_pat_pkg;

    localparam int unsigned DefPatW = 4;
    localparam int unsigned DefCntW = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2,
        StDone  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/pattern_piso.sv
// Parallel-load, MSB-first shift register.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears the register
//   load  : load din (has priority over shift)
//   shift : shift left by one, zero fill
//   din   : parallel load data
//   msb   : current most significant bit
module pattern_piso #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sreg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= '0;
        end else if (load) begin
            sreg_q <= din;
        end else if (shift) begin
            sreg_q <= {sreg_q[W-2:0], 1'b0};
        end
    end

    assign msb = sreg_q[W-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB first,
// repeat_n times, with gap_n idle cycles between transmissions, then pulses done.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   start    : begin a transmission (honoured only in idle)
//   pattern  : bits to send, MSB first
//   repeat_n : number of transmissions
//   gap_n    : idle cycles between consecutive transmissions
//   x        : serial data bit
//   valid    : x carries a pattern bit
//   busy     : transmission or gap in progress
//   done     : one-cycle completion pulse
module serial_pattern_tx
    import serial_pat_pkg::*;
#(
    parameter int unsigned PAT_W = DefPatW,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic [CNT_W-1:0] gap_n,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BitW = $clog2(PAT_W);
    localparam logic [BitW-1:0] TopIdx = BitW'(PAT_W - 1);

    tx_state_e        state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] gap_len_q, gap_len_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [BitW-1:0]  bit_q, bit_d;
    logic             load;
    logic             shift_en;
    logic [PAT_W-1:0] piso_din;
    logic             piso_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pat_q     <= '0;
            gap_len_q <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            bit_q     <= '0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            gap_len_q <= gap_len_d;
            rep_q     <= rep_d;
            gap_q     <= gap_d;
            bit_q     <= bit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        gap_len_d = gap_len_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        bit_d     = bit_q;
        load      = 1'b0;
        shift_en  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pat_d     = pattern;
                    gap_len_d = gap_n;
                    if (repeat_n == '0) begin
                        state_d = StDone;
                        rep_d   = '0;
                    end else begin
                        state_d = StShift;
                        rep_d   = repeat_n;
                        load    = 1'b1;
                        bit_d   = TopIdx;
                    end
                end
            end
            StShift: begin
                if (bit_q != '0) begin
                    shift_en = 1'b1;
                    bit_d    = bit_q - BitW'(1);
                end else begin
                    // Last bit of this transmission: account for it, then decide what follows.
                    if (rep_q != '0) begin
                        rep_d = rep_q - CNT_W'(1);
                    end
                    if (rep_q > CNT_W'(1)) begin
                        if (gap_len_q != '0) begin
                            state_d = StGap;
                            gap_d   = gap_len_q;
                        end else begin
                            load  = 1'b1;
                            bit_d = TopIdx;
                        end
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StGap: begin
                if (gap_q <= CNT_W'(1)) begin
                    state_d = StShift;
                    gap_d   = '0;
                    load    = 1'b1;
                    bit_d   = TopIdx;
                end else begin
                    gap_d = gap_q - CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // First load comes straight from the input port; reloads use the latched copy.
    assign piso_din = (state_q == StIdle) ? pattern : pat_q;

    pattern_piso #(
        .W(PAT_W)
    ) u_piso (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .shift(shift_en),
        .din  (piso_din),
        .msb  (piso_msb)
    );

    // Moore outputs decoded straight from flops, so reset clears them immediately.
    assign valid = (state_q == StShift);
    assign x     = valid & piso_msb;
    assign busy  = (state_q == StShift) || (state_q == StGap);
    assign done  = (state_q == StDone);

endmodule
